// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit, receive and register logic.
//   - tx_state_t      : transmit FSM state encoding
//   - PAR_* constants : line-control parity field encodings
//   - databits_to_n() : maps the 3-bit data-bits code to a bit count
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    // Codes 1xx select 5..8 data bits; 0xx codes fall back to 8 bits.
    function automatic logic [3:0] databits_to_n(input logic [2:0] code);
        if (code[2]) begin
            return {2'b00, code[1:0]} + 4'd5;
        end
        return 4'd8;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
//   Valid/ready byte handshake between the TX FIFO head and the transmitter.
//   Signals:
//     TxData  : byte at the FIFO head, LSB transmitted first
//     TxValid : FIFO non-empty
//     TxReady : pop strobe from the transmitter; transfer on TxValid & TxReady
//   Modports:
//     master : FIFO side (drives data/valid)
//     slave  : transmitter side (drives ready)
// -----------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] TxData;
    logic              TxValid;
    logic              TxReady;

    modport master (
        output TxData,
        output TxValid,
        input  TxReady
    );

    modport slave (
        input  TxData,
        input  TxValid,
        output TxReady
    );
endinterface

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
//   Counts oversample ticks within one bit period and flags the tick that
//   closes the bit. The counter wraps to 0 on that tick, so consecutive bits
//   each last exactly OVERSAMPLE ticks. clear_i holds the counter at 0.
//   Ports:
//     clk_i     : system clock
//     rst_ni    : synchronous active-low reset
//     tick_i    : 1-cycle oversample tick
//     clear_i   : hold counter at zero (idle / abort)
//     bit_end_o : high on the tick that ends the current bit
//     count_o   : current tick count within the bit
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16,
    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          tick_i,
    input  logic          clear_i,
    output logic          bit_end_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last   = (cnt_q == LAST);
    assign bit_end_o = tick_i & ~clear_i & at_last;
    assign count_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmit serializer. Pops bytes from the TX FIFO over a valid/ready
//   handshake, frames them (start, 5..8 data bits LSB first, optional parity,
//   1 or 2 stop bits) and drives TXD. Bit timing comes from an oversampled
//   baud tick.
//   Ports:
//     DSP_CLK    : system clock
//     RESETn     : synchronous active-low reset
//     BaudTick16 : oversample tick, OVERSAMPLE pulses per bit
//     UARTEn     : global enable; dropping it aborts the frame in progress
//     TxEn       : transmitter enable; dropping it blocks the next accept only
//     Parity     : 00 none, 01 odd, 10 even, 11 mark
//     StopBits   : 0 one stop bit, 1 two stop bits
//     DataBits   : data bits minus one (1xx), 0xx means 8
//     tx_if      : FIFO handshake (TxData, TxValid in; TxReady out)
//     TXD        : serial line, idle high
//     TxBusy     : frame in progress
//     TxDone     : 1-cycle pulse on the tick that ends the last stop bit
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8
) (
    input  logic         DSP_CLK,
    input  logic         RESETn,
    input  logic         BaudTick16,
    input  logic         UARTEn,
    input  logic         TxEn,
    input  logic [1:0]   Parity,
    input  logic         StopBits,
    input  logic [2:0]   DataBits,
    uart_tx_if.slave     tx_if,
    output logic         TXD,
    output logic         TxBusy,
    output logic         TxDone
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    tx_state_t         state_q,    state_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic [3:0]        bit_idx_q,  bit_idx_d;
    logic [3:0]        last_idx_q, last_idx_d;
    logic              par_en_q,   par_en_d;
    logic              par_bit_q,  par_bit_d;
    logic              stop2_q,    stop2_d;
    logic              stop_cnt_q, stop_cnt_d;

    logic              tx_ready;
    logic              accept;
    logic              tx_done;
    logic              txd;
    logic              timer_clear;
    logic              bit_end;
    logic [CW-1:0]     tick_count;

    logic [3:0]        accept_n;
    logic [DATA_W-1:0] data_mask;
    logic [DATA_W-1:0] data_masked;
    logic              accept_par;

    // Ticks only count while a frame is on the line; this also discards a
    // tick that lands on the accept cycle.
    assign timer_clear = (state_q == TX_IDLE) | ~UARTEn;

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk_i     (DSP_CLK),
        .rst_ni    (RESETn),
        .tick_i    (BaudTick16),
        .clear_i   (timer_clear),
        .bit_end_o (bit_end),
        .count_o   (tick_count)
    );

    // Ready is held low during reset so nothing is popped in that cycle.
    assign tx_ready     = RESETn & UARTEn & TxEn & (state_q == TX_IDLE);
    assign accept       = tx_ready & tx_if.TxValid;
    assign tx_if.TxReady = tx_ready;

    // Parity covers only the active data bits, so mask the FIFO byte by the
    // selected width before reducing it.
    assign accept_n = databits_to_n(DataBits);

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
        assign data_mask[gi] = (accept_n > 4'(gi));
    end

    assign data_masked = tx_if.TxData & data_mask;

    always_comb begin
        accept_par = 1'b1;
        case (Parity)
            PAR_ODD:  accept_par = ~^data_masked;
            PAR_EVEN: accept_par = ^data_masked;
            default:  accept_par = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        last_idx_d = last_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        tx_done    = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    // Shadow the byte and line config for the whole frame.
                    shift_d    = tx_if.TxData;
                    last_idx_d = accept_n - 4'd1;
                    par_en_d   = (Parity != PAR_NONE);
                    par_bit_d  = accept_par;
                    stop2_d    = StopBits;
                    bit_idx_d  = 4'd0;
                    stop_cnt_d = 1'b0;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    bit_idx_d = 4'd0;
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == last_idx_q) begin
                        stop_cnt_d = 1'b0;
                        state_d    = par_en_q ? TX_PARITY : TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    stop_cnt_d = 1'b0;
                    state_d    = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        tx_done = 1'b1;
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        // Global disable abandons the frame; the byte is dropped silently.
        if (!UARTEn) begin
            state_d    = TX_IDLE;
            bit_idx_d  = 4'd0;
            stop_cnt_d = 1'b0;
            tx_done    = 1'b0;
        end
    end

    always_ff @(posedge DSP_CLK) begin
        if (!RESETn) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= 4'd0;
            last_idx_q <= 4'd0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            last_idx_q <= last_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    // Line level follows the registered state, so TXD moves on the cycle
    // after each bit-ending tick.
    always_comb begin
        txd = 1'b1;
        case (state_q)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = shift_q[0];
            TX_PARITY: txd = par_bit_q;
            default:   txd = 1'b1;
        endcase
    end

    assign TXD    = txd;
    assign TxBusy = (state_q != TX_IDLE);
    assign TxDone = tx_done & RESETn;

    // The in-bit count is exported for debug visibility only.
    logic unused_ok;
    assign unused_ok = ^tick_count;

endmodule
